// File: rtl/ode_step_commit_if.sv
// Control, step/time and register-file port bundle for the ODE step commit stage.
interface ode_step_commit_if #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     init;
  logic                     commit;
  logic [WORD_SIZE-1:0]     step_in;
  logic [WORD_SIZE-1:0]     n_in;
  logic [WORD_SIZE-1:0]     t0_in;
  logic [WORD_SIZE-1:0]     t_final_in;
  logic [ADDRESS_WIDTH-1:0] x0_base;
  logic [ADDRESS_WIDTH-1:0] x1_base;
  logic [WORD_SIZE-1:0]     mem_rd_data;
  logic [ADDRESS_WIDTH-1:0] mem_rd_addr;
  logic [ADDRESS_WIDTH-1:0] mem_wr_addr;
  logic [WORD_SIZE-1:0]     mem_wr_data;
  logic                     mem_wr_en;
  logic                     busy;
  logic                     commit_done;
  logic [WORD_SIZE-1:0]     next_step;
  logic                     next_step_valid;
  logic [WORD_SIZE-1:0]     time_out;
  logic                     finished;
  logic                     overflow;

  modport master (
    output init, commit, step_in, n_in, t0_in, t_final_in, x0_base, x1_base,
           mem_rd_data,
    input  mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en, busy, commit_done,
           next_step, next_step_valid, time_out, finished, overflow
  );

  modport slave (
    input  init, commit, step_in, n_in, t0_in, t_final_in, x0_base, x1_base,
           mem_rd_data,
    output mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en, busy, commit_done,
           next_step, next_step_valid, time_out, finished, overflow
  );
endinterface

// File: rtl/ode_step_commit.sv
// Commits an accepted ODE step: copies x1 over x0, advances t by h and
// produces the next step, clamped so t lands exactly on t_final.
module ode_step_commit #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  ode_step_commit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COPY, UPDATE, DONE} state_e;

  state_e                        state_q, state_d;
  logic signed [WORD_SIZE-1:0]   t_q, t_d;
  logic signed [WORD_SIZE-1:0]   tf_q, tf_d;
  logic signed [WORD_SIZE-1:0]   h_q, h_d;
  logic signed [WORD_SIZE-1:0]   next_step_q, next_step_d;
  logic [WORD_SIZE-1:0]          n_q, n_d;
  logic [WORD_SIZE-1:0]          i_q, i_d;
  logic                          finished_q, finished_d;
  logic                          overflow_q, overflow_d;

  logic signed [WORD_SIZE-1:0]   sum;
  logic                          sum_ovf;
  logic signed [WORD_SIZE-1:0]   t_new;
  logic signed [WORD_SIZE:0]     rem;
  logic signed [WORD_SIZE:0]     h_ext;
  logic                          rem_pos;
  logic                          last_word;

  // Step arithmetic; only consumed in UPDATE. rem is one bit wider so tf - t
  // cannot wrap even when t has just saturated or h is negative.
  always_comb begin
    sum       = t_q + h_q;
    sum_ovf   = (t_q[WORD_SIZE-1] == h_q[WORD_SIZE-1]) &&
                (sum[WORD_SIZE-1] != t_q[WORD_SIZE-1]);
    t_new     = sum_ovf ? tf_q : sum;
    rem       = {tf_q[WORD_SIZE-1], tf_q} - {t_new[WORD_SIZE-1], t_new};
    h_ext     = {h_q[WORD_SIZE-1], h_q};
    rem_pos   = !rem[WORD_SIZE] && (rem != '0);
    last_word = (i_q == n_q - WORD_SIZE'(1));
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    t_d             = t_q;
    tf_d            = tf_q;
    h_d             = h_q;
    n_d             = n_q;
    i_d             = i_q;
    next_step_d     = next_step_q;
    finished_d      = finished_q;
    overflow_d      = overflow_q;
    bus.mem_rd_addr = '0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.init) begin
          t_d        = bus.t0_in;
          tf_d       = bus.t_final_in;
          finished_d = 1'b0;
          overflow_d = 1'b0;
        end else if (bus.commit && !finished_q) begin
          h_d     = bus.step_in;
          n_d     = bus.n_in;
          i_d     = '0;
          state_d = (bus.n_in == '0) ? UPDATE : COPY;
        end
      end

      COPY: begin
        bus.mem_rd_addr = bus.x1_base + i_q[ADDRESS_WIDTH-1:0];
        bus.mem_wr_addr = bus.x0_base + i_q[ADDRESS_WIDTH-1:0];
        bus.mem_wr_data = bus.mem_rd_data;
        bus.mem_wr_en   = 1'b1;
        i_d             = i_q + WORD_SIZE'(1);
        if (last_word) state_d = UPDATE;
      end

      UPDATE: begin
        // next_step is settled here so it is already valid while DONE pulses.
        t_d = t_new;
        if (sum_ovf) begin
          overflow_d = 1'b1;
          finished_d = 1'b1;
        end
        if (!rem_pos) begin
          finished_d  = 1'b1;
          next_step_d = h_q;
        end else if (rem < h_ext) begin
          next_step_d = rem[WORD_SIZE-1:0];
        end else begin
          next_step_d = h_q;
        end
        state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      tf_q        <= '0;
      h_q         <= '0;
      n_q         <= '0;
      i_q         <= '0;
      next_step_q <= '0;
      finished_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      tf_q        <= tf_d;
      h_q         <= h_d;
      n_q         <= n_d;
      i_q         <= i_d;
      next_step_q <= next_step_d;
      finished_q  <= finished_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy            = (state_q != IDLE);
  assign bus.commit_done     = (state_q == DONE);
  assign bus.next_step_valid = (state_q == DONE);
  assign bus.next_step       = next_step_q;
  assign bus.time_out        = t_q;
  assign bus.finished        = finished_q;
  assign bus.overflow        = overflow_q;

endmodule

// File: tb/tb_ode_step_commit.sv
// Directed bench for ode_step_commit: vector table plus multi-cycle corner sequences.
module tb_ode_step_commit;
  localparam int W  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ode_step_commit_if #(.WORD_SIZE(W), .ADDRESS_WIDTH(AW)) bus ();

  ode_step_commit #(.WORD_SIZE(W), .ADDRESS_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Register-file model with combinational read.
  logic [W-1:0] mem [16];
  logic         mem_reload;
  int           wr_count;

  function automatic logic [W-1:0] orig(input int a);
    logic [W-1:0] v;
    v = 16'(256 + a * 7);
    return v;
  endfunction

  function automatic int sx(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  assign bus.mem_rd_data = mem[bus.mem_rd_addr];

  always @(posedge clk) begin
    if (mem_reload) begin
      for (int k = 0; k < 16; k++) mem[k] <= orig(k);
      wr_count <= 0;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_wr_addr] <= bus.mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int t0, tf, h, n, x0, x1;
    int e_time, e_next, e_fin, e_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic idle_inputs();
    bus.init       = 1'b0;
    bus.commit     = 1'b0;
    bus.step_in    = '0;
    bus.n_in       = '0;
    bus.t0_in      = '0;
    bus.t_final_in = '0;
    bus.x0_base    = '0;
    bus.x1_base    = '0;
  endtask

  task automatic reload_mem();
    mem_reload = 1'b1;
    @(negedge clk);
    mem_reload = 1'b0;
  endtask

  task automatic do_init(input int t0, input int tf);
    bus.init       = 1'b1;
    bus.t0_in      = 16'(t0);
    bus.t_final_in = 16'(tf);
    @(negedge clk);
    bus.init       = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (first cycle after commit is sampled).
  task automatic do_commit(input int h, input int n, input int x0, input int x1);
    bus.commit  = 1'b1;
    bus.step_in = 16'(h);
    bus.n_in    = 16'(n);
    bus.x0_base = 4'(x0);
    bus.x1_base = 4'(x1);
    @(negedge clk);
    bus.commit  = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!bus.commit_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", int'(bus.commit_done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int bad;
    int wc;

    vecs[0] = '{0,      100,   10,  3, 4,  8,  10,    10,  0, 0};
    vecs[1] = '{95,     100,   10,  0, 0,  0,  105,   10,  1, 0};
    vecs[2] = '{92,     100,   5,   0, 0,  0,  97,    3,   0, 0};
    vecs[3] = '{90,     100,   10,  2, 0,  4,  100,   10,  1, 0};
    vecs[4] = '{32760,  32000, 100, 1, 3,  15, 32000, 100, 1, 1};
    vecs[5] = '{0,      50,    -5,  0, 0,  0,  -5,    -5,  0, 0};
    vecs[6] = '{0,      100,   20,  3, 2,  14, 20,    20,  0, 0};
    vecs[7] = '{-100,   -40,   70,  1, 9,  1,  -30,   70,  1, 0};
    vecs[8] = '{0,      30,    20,  2, 12, 5,  20,    10,  0, 0};

    idle_inputs();
    mem_reload = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mem_reload = 1'b0;

    // Reset state and quiet idle.
    check("rst_busy",        int'(bus.busy), 0);
    check("rst_commit_done", int'(bus.commit_done), 0);
    check("rst_nsv",         int'(bus.next_step_valid), 0);
    check("rst_wr_en",       int'(bus.mem_wr_en), 0);
    check("rst_time",        sx(bus.time_out), 0);
    check("rst_next_step",   sx(bus.next_step), 0);
    check("rst_finished",    int'(bus.finished), 0);
    check("rst_overflow",    int'(bus.overflow), 0);
    check("rst_addrs",       int'(bus.mem_rd_addr) + int'(bus.mem_wr_addr), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_wr_en || bus.busy) bad++;
    end
    check("idle_quiet", bad, 0);

    // Table-driven steps.
    foreach (vecs[v]) begin
      reload_mem();
      do_init(vecs[v].t0, vecs[v].tf);
      check($sformatf("v%0d_init_time", v), sx(bus.time_out), vecs[v].t0);
      check($sformatf("v%0d_init_fin", v), int'(bus.finished), 0);
      do_commit(vecs[v].h, vecs[v].n, vecs[v].x0, vecs[v].x1);
      check($sformatf("v%0d_busy", v), int'(bus.busy), 1);
      wait_done(1, cyc);
      check($sformatf("v%0d_latency", v), cyc, vecs[v].n + 2);
      check($sformatf("v%0d_nsv", v), int'(bus.next_step_valid), 1);
      check($sformatf("v%0d_time", v), sx(bus.time_out), vecs[v].e_time);
      check($sformatf("v%0d_next", v), sx(bus.next_step), vecs[v].e_next);
      check($sformatf("v%0d_fin", v), int'(bus.finished), vecs[v].e_fin);
      check($sformatf("v%0d_ovf", v), int'(bus.overflow), vecs[v].e_ovf);
      check($sformatf("v%0d_writes", v), wr_count, vecs[v].n);
      for (int k = 0; k < vecs[v].n; k++) begin
        check($sformatf("v%0d_copy%0d", v, k),
              int'(mem[(vecs[v].x0 + k) % 16]), int'(orig((vecs[v].x1 + k) % 16)));
      end
      @(negedge clk);
      check($sformatf("v%0d_idle_after", v), int'(bus.busy) + int'(bus.next_step_valid), 0);
      check($sformatf("v%0d_next_hold", v), sx(bus.next_step), vecs[v].e_next);
    end

    // Exact finish, then a commit while finished must be ignored.
    reload_mem();
    do_init(90, 100);
    do_commit(10, 0, 0, 0);
    wait_done(1, cyc);
    check("pf_finished", int'(bus.finished), 1);
    @(negedge clk);
    wc = wr_count;
    do_commit(10, 2, 0, 4);
    bad = 0;
    repeat (8) begin
      if (bus.busy || bus.commit_done || bus.mem_wr_en) bad++;
      @(negedge clk);
    end
    check("pf_ignored", bad, 0);
    check("pf_no_writes", wr_count, wc);
    check("pf_time_hold", sx(bus.time_out), 100);

    // commit/init while busy are ignored.
    reload_mem();
    do_init(0, 100);
    do_commit(10, 4, 0, 8);
    bus.commit  = 1'b1;
    bus.init    = 1'b1;
    bus.t0_in   = 16'd50;
    bus.step_in = 16'd99;
    @(negedge clk);
    bus.commit  = 1'b0;
    bus.init    = 1'b0;
    wait_done(2, cyc);
    check("busy_latency", cyc, 6);
    check("busy_time", sx(bus.time_out), 10);
    check("busy_next", sx(bus.next_step), 10);
    check("busy_writes", wr_count, 4);
    @(negedge clk);
    check("busy_no_requeue", int'(bus.busy), 0);

    // Reset in the middle of COPY.
    reload_mem();
    do_init(40, 100);
    do_commit(10, 5, 0, 8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_writes", wr_count, 3);
    check("mid_busy", int'(bus.busy), 0);
    check("mid_wr_en", int'(bus.mem_wr_en), 0);
    check("mid_time", sx(bus.time_out), 0);
    check("mid_next", sx(bus.next_step), 0);
    check("mid_done", int'(bus.commit_done), 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_wr_en || bus.busy) bad++;
    end
    check("mid_quiet", bad + wr_count, 3);

    // init and commit in the same IDLE cycle: init wins, commit dropped.
    wc = wr_count;
    bus.init       = 1'b1;
    bus.t0_in      = 16'd20;
    bus.t_final_in = 16'd60;
    bus.commit     = 1'b1;
    bus.step_in    = 16'd7;
    bus.n_in       = 16'd1;
    bus.x0_base    = 4'd0;
    bus.x1_base    = 4'd8;
    @(negedge clk);
    bus.init   = 1'b0;
    bus.commit = 1'b0;
    check("ic_time", sx(bus.time_out), 20);
    bad = 0;
    repeat (5) begin
      if (bus.busy || bus.commit_done) bad++;
      @(negedge clk);
    end
    check("ic_dropped", bad, 0);
    check("ic_no_writes", wr_count, wc);
    check("ic_fin", int'(bus.finished), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
